// File: rtl/esm_issue_scheduler.sv
// rtl/esm_issue_scheduler.sv - ESM buffer slot allocator and round-robin issue scheduler
// Optional statistics outputs (occupancy, stall_cnt) built when ESM_SCHED_STATS_EN is defined.
module esm_issue_scheduler #(
   parameter int Instruction_word_size = 32,
   parameter int bs                    = 16,
   parameter int SETTLE                = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [Instruction_word_size-1:0] in_instr,
   output logic                             ida_we,
   output logic [$clog2(bs)-1:0]            ida_index,
   output logic [0:bs-1]                    valid_entries,
   input  logic [0:bs-1]                    independent_instr,
   output logic                             issue_valid,
   input  logic                             issue_ready,
   output logic [$clog2(bs)-1:0]            issue_index,
   output logic [Instruction_word_size-1:0] issue_instr,
   input  logic                             complete_valid,
   input  logic [$clog2(bs)-1:0]            complete_index,
   output logic                             err_bad_complete
`ifdef ESM_SCHED_STATS_EN
   ,
   output logic [$clog2(bs):0]              occupancy,
   output logic [15:0]                      stall_cnt
`endif
);

   localparam int IW = $clog2(bs);
   localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

   typedef enum logic [1:0] {S_FREE, S_SETTLING, S_WAITING, S_ISSUED} slot_state_e;

   slot_state_e                      state_q [bs];
   slot_state_e                      state_d [bs];
   logic [CW-1:0]                    cnt_q   [bs];
   logic [CW-1:0]                    cnt_d   [bs];
   logic [Instruction_word_size-1:0] mem     [bs];
   logic [IW-1:0]                    rr_q;
   logic [IW-1:0]                    alloc_slot;
   logic [IW-1:0]                    cand_slot;
   logic [bs-1:0]                    free_vec;
   logic [bs-1:0]                    elig_vec;
   logic                             alloc_ok;
   logic                             cand_found;
   logic                             hs;
   logic                             complete_ok;

   // Lowest-numbered free slot; looking only at registered state keeps a slot freed this cycle out of reach.
   always_comb begin
      free_vec   = '0;
      elig_vec   = '0;
      alloc_slot = '0;
      for (int i = bs - 1; i >= 0; i--) begin
         free_vec[i] = (state_q[i] == S_FREE);
         elig_vec[i] = (state_q[i] == S_WAITING) && independent_instr[i];
         valid_entries[i] = (state_q[i] != S_FREE);
         if (state_q[i] == S_FREE) alloc_slot = IW'(i);
      end
   end

   assign in_ready    = |free_vec;
   assign alloc_ok    = in_valid && in_ready;
   assign hs          = issue_valid && issue_ready;
   assign complete_ok = complete_valid && (state_q[complete_index] == S_ISSUED);

   // Round-robin search: offsets are scanned downwards so the slot nearest rr_q wins.
   always_comb begin
      cand_found = 1'b0;
      cand_slot  = '0;
      for (int k = bs - 1; k >= 0; k--) begin
         if (elig_vec[rr_q + IW'(k)]) begin
            cand_found = 1'b1;
            cand_slot  = rr_q + IW'(k);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < bs; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         if (state_q[i] == S_SETTLING) begin
            if (cnt_q[i] <= CW'(1)) begin
               state_d[i] = S_WAITING;
               cnt_d[i]   = '0;
            end else begin
               cnt_d[i] = cnt_q[i] - CW'(1);
            end
         end
      end
      if (alloc_ok) begin
         state_d[alloc_slot] = (SETTLE == 0) ? S_WAITING : S_SETTLING;
         cnt_d[alloc_slot]   = CW'(SETTLE);
      end
      if (hs) state_d[issue_index] = S_ISSUED;
      if (complete_ok) state_d[complete_index] = S_FREE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < bs; i++) begin
            state_q[i] <= S_FREE;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < bs; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_ok) mem[alloc_slot] <= in_instr;
   end

   // Issue outputs are frozen while offered; a new candidate loads only after the handshake cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ida_we           <= 1'b0;
         ida_index        <= '0;
         issue_valid      <= 1'b0;
         issue_index      <= '0;
         issue_instr      <= '0;
         rr_q             <= '0;
         err_bad_complete <= 1'b0;
      end else begin
         ida_we <= alloc_ok;
         if (alloc_ok) ida_index <= alloc_slot;
         if (hs) begin
            issue_valid <= 1'b0;
            rr_q        <= issue_index + IW'(1);
         end else if (!issue_valid && cand_found) begin
            issue_valid <= 1'b1;
            issue_index <= cand_slot;
            issue_instr <= mem[cand_slot];
         end
         if (complete_valid && !complete_ok) err_bad_complete <= 1'b1;
      end
   end

`ifdef ESM_SCHED_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occupancy <= '0;
         stall_cnt <= '0;
      end else begin
         if (alloc_ok && !complete_ok) occupancy <= occupancy + 1'b1;
         else if (!alloc_ok && complete_ok) occupancy <= occupancy - 1'b1;
         if (in_valid && !in_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      end
   end
`else
   // statistics counters not built
`endif

endmodule
